// File: rtl/usb_tx_pkg.sv
// ---------------------------------------------------------------------------
// types -- shared definitions for the low-speed USB transmit path.
//
// Contents:
//   d_port_t      line state driven onto D+/D- as {D+, D-}.
//                 Low speed: J = D- high, K = D+ high, SE0 = both low.
//   tx_state_t    transmitter FSM states (IDLE, SYNC, DATA, EOP).
//   SYNC_PATTERN  SYNC byte, sent LSB first through the NRZI encoder.
//   STUFF_LIMIT   consecutive ones after which a stuff bit is inserted.
// ---------------------------------------------------------------------------
package types;

    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10
    } d_port_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam int         STUFF_LIMIT  = 6;

endpackage : types

// File: rtl/usb_tx_nrzi_stuff_enc.sv
// ---------------------------------------------------------------------------
// nrzi_stuff_enc -- NRZI encoder with bit-stuffing bookkeeping.
//
// Holds the current J/K line level and the count of consecutive ones.
// On every strobe one bit time is launched:
//   - if a stuff bit is owed (ones count reached STUFF_LIMIT) the line
//     toggles, the count clears and bit_i is ignored;
//   - otherwise a 0 toggles the line (count clears), a 1 holds it (count+1).
// The caller sees stuff_o and must keep bit_i pending while it is high.
//
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   strobe_i   launch one bit time this clock
//   bit_i      data bit to launch
//   init_i     force level to J and clear the ones count (idle line)
//   level_j_o  1 = line at J, 0 = line at K
//   stuff_o    next strobe will launch a stuff bit
// ---------------------------------------------------------------------------
module nrzi_stuff_enc
    import types::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    input  logic bit_i,
    input  logic init_i,
    output logic level_j_o,
    output logic stuff_o
);

    logic       level_j_q, level_j_d;
    logic [2:0] ones_q, ones_d;

    assign stuff_o   = (ones_q == 3'(STUFF_LIMIT));
    assign level_j_o = level_j_q;

    always_comb begin
        level_j_d = level_j_q;
        ones_d    = ones_q;
        if (init_i) begin
            level_j_d = 1'b1;
            ones_d    = '0;
        end else if (strobe_i) begin
            if (stuff_o || !bit_i) begin
                level_j_d = ~level_j_q;
                ones_d    = '0;
            end else begin
                ones_d    = ones_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_j_q <= 1'b1;
            ones_q    <= '0;
        end else begin
            level_j_q <= level_j_d;
            ones_q    <= ones_d;
        end
    end

endmodule : nrzi_stuff_enc

// File: rtl/usb_tx.sv
// ---------------------------------------------------------------------------
// usb_tx -- low-speed USB (1.5 Mbit/s) serial transmitter.
//
// Takes bytes over a valid/ready handshake and drives the bus as d_port_t
// line states: SYNC, NRZI data with bit stuffing, then EOP (SE0, SE0, J).
//
// Handshake: tx_ready is a one-clock pulse on the last clock of the final
// bit of SYNC or of a byte (the byte boundary). The byte is taken on the
// clock edge where tx_valid && tx_ready; tx_valid low at a boundary ends the
// packet. tx_data/tx_valid are ignored between boundaries.
//
// Optional feature (macro USB_TX_KEEPALIVE_EN): adds the keepalive input;
// a keepalive request in IDLE sends a bare EOP. tx_valid has priority.
//
// Ports:
//   clk        24 MHz clock
//   reset      asynchronous active-low reset
//   tx_data    byte to send, LSB first
//   tx_valid   byte available
//   keepalive  bare-EOP request (only with USB_TX_KEEPALIVE_EN)
//   tx_ready   byte-boundary pulse
//   q          line state (J, K, SE0)
//   oe         bus drive enable
//   busy       packet in progress
// ---------------------------------------------------------------------------
module usb_tx
    import types::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
`ifdef USB_TX_KEEPALIVE_EN
    input  logic       keepalive,
`endif
    output logic       tx_ready,
    output d_port_t    q,
    output logic       oe,
    output logic       busy
);

    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    tx_state_t       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0]      sr_q, sr_d;        // bits not yet launched, LSB next
    logic [3:0]      bit_cnt_q, bit_cnt_d; // bits of SYNC/byte launched so far
    logic [1:0]      eop_cnt_q, eop_cnt_d; // EOP bit time: 0,1 = SE0, 2 = J

    logic wrap;
    logic in_bits;
    logic boundary;
    logic ka_req;
    logic enc_strobe;
    logic enc_bit;
    logic enc_init;
    logic level_j;
    logic stuff_req;

`ifdef USB_TX_KEEPALIVE_EN
    assign ka_req = keepalive;
`else
    assign ka_req = 1'b0;
`endif

    assign wrap     = (tmr_q == TMR_LAST);
    assign in_bits  = (state_q == SYNC) || (state_q == DATA);
    // A pending stuff bit pushes the boundary out by one bit time.
    assign boundary = in_bits && wrap && (bit_cnt_q == 4'd8) && !stuff_req;
    assign enc_init = (state_q == IDLE);

    nrzi_stuff_enc u_enc (
        .clk_i     (clk),
        .rst_ni    (reset),
        .strobe_i  (enc_strobe),
        .bit_i     (enc_bit),
        .init_i    (enc_init),
        .level_j_o (level_j),
        .stuff_o   (stuff_req)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = SYNC;
                end else if (ka_req) begin
                    state_d = EOP;
                end
            end
            SYNC, DATA: begin
                if (boundary) begin
                    state_d = tx_valid ? DATA : EOP;
                end
            end
            EOP: begin
                if (wrap && (eop_cnt_q == 2'd2)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        tmr_d      = tmr_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        eop_cnt_d  = eop_cnt_q;
        enc_strobe = 1'b0;
        enc_bit    = sr_q[0];
        case (state_q)
            IDLE: begin
                tmr_d     = '0;
                bit_cnt_d = '0;
                eop_cnt_d = '0;
                if (tx_valid) begin
                    // Preload so the first SYNC bit launches on the next
                    // edge: the line goes K one clock after tx_valid is seen.
                    tmr_d = TMR_LAST;
                    sr_d  = SYNC_PATTERN;
                end
            end
            SYNC, DATA: begin
                tmr_d = wrap ? '0 : tmr_q + TMR_W'(1);
                if (wrap) begin
                    if (stuff_req) begin
                        enc_strobe = 1'b1;
                    end else if (bit_cnt_q == 4'd8) begin
                        if (tx_valid) begin
                            enc_strobe = 1'b1;
                            enc_bit    = tx_data[0];
                            sr_d       = {1'b0, tx_data[7:1]};
                            bit_cnt_d  = 4'd1;
                        end else begin
                            eop_cnt_d  = '0;
                        end
                    end else begin
                        enc_strobe = 1'b1;
                        enc_bit    = sr_q[0];
                        sr_d       = {1'b0, sr_q[7:1]};
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                    end
                end
            end
            EOP: begin
                tmr_d = wrap ? '0 : tmr_q + TMR_W'(1);
                if (wrap) begin
                    eop_cnt_d = (eop_cnt_q == 2'd2) ? 2'd0 : eop_cnt_q + 2'd1;
                end
            end
            default: begin
                tmr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_q     <= '0;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            eop_cnt_q <= '0;
        end else begin
            tmr_q     <= tmr_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            eop_cnt_q <= eop_cnt_d;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        q        = J;
        oe       = 1'b0;
        busy     = 1'b0;
        tx_ready = boundary;
        case (state_q)
            IDLE: begin
                q    = J;
                oe   = 1'b0;
                busy = 1'b0;
            end
            SYNC: begin
                // First clock in SYNC is the launch delay: line still idle.
                oe   = (bit_cnt_q != 4'd0);
                busy = (bit_cnt_q != 4'd0);
                q    = level_j ? J : K;
            end
            DATA: begin
                oe   = 1'b1;
                busy = 1'b1;
                q    = level_j ? J : K;
            end
            EOP: begin
                oe   = 1'b1;
                busy = 1'b1;
                q    = (eop_cnt_q == 2'd2) ? J : SE0;
            end
            default: begin
                q = J;
            end
        endcase
    end

endmodule : usb_tx

// File: tb/tb_usb_tx.sv
// ---------------------------------------------------------------------------
// tb_usb_tx -- self-checking bench for usb_tx.
// Expected line symbols are queued as each packet is set up and compared at
// the middle of every bit time while oe is high; packet length in clocks
// and tx_ready pulse counts are compared when oe falls.
// Define USB_TX_KEEPALIVE_EN to include the keep-alive steps.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_tx;
    import types::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    d_port_t    q;
    logic       oe;
    logic       busy;
`ifdef USB_TX_KEEPALIVE_EN
    logic       keepalive = 1'b0;
`endif

    always #20 clk = ~clk;

    usb_tx #(.CLKS_PER_BIT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
`ifdef USB_TX_KEEPALIVE_EN
        .keepalive (keepalive),
`endif
        .tx_ready  (tx_ready),
        .q         (q),
        .oe        (oe),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_q[$];
    int len_q[$];
    int rdy_q[$];
    int rdy_cyc[$];
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 'J', 'K', '0' (SE0)
    task automatic push_seq(input string s);
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "J":     exp_q.push_back(J);
                "K":     exp_q.push_back(K);
                default: exp_q.push_back(SE0);
            endcase
        end
    endtask

    task automatic expect_pkt(input string s, input int rdy);
        push_seq(s);
        len_q.push_back(s.len() * 16);
        rdy_q.push_back(rdy);
    endtask

    // ---------------- monitor ----------------
    int   phase = 0, oe_cnt = 0, rdy_cnt = 0, se0_cnt = 0;
    logic oe_prev = 1'b0, rdy_prev = 1'b0;
    logic mon_abort = 1'b0, track_se0 = 1'b0;

    always @(negedge clk) begin
        logic [1:0] e;
        if (oe && !oe_prev) begin
            phase = 0; oe_cnt = 0; rdy_cnt = 0;
        end
        if (oe) begin
            oe_cnt++;
            if (phase == 7) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b11;
                chk("line", 32'(q), 32'(e));
            end
            phase = (phase == 15) ? 0 : phase + 1;
        end
        if (tx_ready) begin
            rdy_cnt++;
            chk("ready_width", 32'(rdy_prev), 32'd0);
        end
        if (!oe && oe_prev && !mon_abort) begin
            chk("oe_len", oe_cnt, (len_q.size() > 0) ? len_q.pop_front() : -1);
            chk("ready_cnt", rdy_cnt, (rdy_q.size() > 0) ? rdy_q.pop_front() : -1);
            chk("bits_left", exp_q.size(), 0);
        end
        if (track_se0 && q == SE0) se0_cnt++;
        oe_prev  = oe;
        rdy_prev = tx_ready;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready && n < 2000);
        chk({tag, "_ready_seen"}, 32'(tx_ready), 32'd1);
        rdy_cyc.push_back(cyc);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        chk("busy_drop", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b0, input logic [7:0] b1, input int n,
                        input logic chk_start);
        rdy_cyc.delete();
        @(negedge clk);
        tx_data  = b0;
        tx_valid = 1'b1;
        if (chk_start) begin
            @(posedge clk); #1;
            chk("start_oe_n", 32'(oe), 32'd0);
            chk("start_q_n", 32'(q), 32'(J));
            @(posedge clk); #1;
            chk("start_oe_n1", 32'(oe), 32'd1);
            chk("start_busy_n1", 32'(busy), 32'd1);
            chk("start_q_n1", 32'(q), 32'(K));
        end
        for (int i = 0; i < n; i++) begin
            wait_ready("byte");
            @(posedge clk); #1;
            if (i + 1 < n) tx_data = b1;
            else tx_valid = 1'b0;
        end
        wait_ready("final");
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #5;
        chk("rst_q", 32'(q), 32'(J));
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // single byte 0x00
        expect_pkt({"KJKJKJKK", "JKJKJKJK", "00J"}, 2);
        send(8'h00, 8'h00, 1, 1'b1);
        chk("gap_00", rdy_cyc[1] - rdy_cyc[0], 128);

        // single byte 0xFF: five ones, stuff, three ones
        expect_pkt({"KJKJKJKK", "KKKKKJJJJ", "00J"}, 2);
        send(8'hFF, 8'h00, 1, 1'b0);
        chk("gap_ff_stuff", rdy_cyc[1] - rdy_cyc[0], 144);

        // 0xFC: stuff bit after the final data bit, before EOP
        expect_pkt({"KJKJKJKK", "JKKKKKKKJ", "00J"}, 2);
        send(8'hFC, 8'h00, 1, 1'b0);
        chk("gap_fc_stuff", rdy_cyc[1] - rdy_cyc[0], 144);

        // two bytes 0xA5, 0x3C
        expect_pkt({"KJKJKJKK", "KJJKJJKK", "JKKKKKJK", "00J"}, 3);
        send(8'hA5, 8'h3C, 2, 1'b0);
        chk("accept_gap", rdy_cyc[1] - rdy_cyc[0], 128);
        chk("final_gap", rdy_cyc[2] - rdy_cyc[1], 128);

        // tx_valid/tx_data disturbed mid-byte, restored before the boundary
        expect_pkt({"KJKJKJKK", "JKJKJKJK", "JKJKJKJK", "00J"}, 3);
        @(negedge clk);
        tx_data = 8'h00; tx_valid = 1'b1;
        wait_ready("glitch0");
        @(posedge clk); #1;
        repeat (40) @(negedge clk);
        tx_valid = 1'b0; tx_data = 8'hFF;
        repeat (20) @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h00;
        wait_ready("glitch1");
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_ready("glitch_final");
        wait_idle();

        // reset during the 3rd data bit
        push_seq({"KJKJKJKK", "JKJKJKJK", "00J"});
        mon_abort = 1'b1; track_se0 = 1'b1; se0_cnt = 0;
        @(negedge clk);
        tx_data = 8'h00; tx_valid = 1'b1;
        wait_ready("rst_pkt");
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_q", 32'(q), 32'(J));
        chk("midrst_oe", 32'(oe), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(tx_ready), 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (400) @(negedge clk);
        chk("no_se0", se0_cnt, 0);
        chk("post_rst_oe", 32'(oe), 32'd0);
        track_se0 = 1'b0;
        mon_abort = 1'b0;
        exp_q.delete();

`ifdef USB_TX_KEEPALIVE_EN
        // bare EOP
        expect_pkt("00J", 0);
        @(negedge clk);
        keepalive = 1'b1;
        @(negedge clk);
        keepalive = 1'b0;
        wait_idle();

        // tx_valid wins over keepalive
        expect_pkt({"KJKJKJKK", "JKJKJKJK", "00J"}, 2);
        @(negedge clk);
        keepalive = 1'b1; tx_data = 8'h00; tx_valid = 1'b1;
        @(negedge clk);
        keepalive = 1'b0;
        wait_ready("ka_byte");
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_ready("ka_final");
        wait_idle();
`endif

        repeat (8) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_usb_tx
